// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_sequencer_pkg                                                      |
// | Addressing-mode codes, FSM state encodings, operand-count tables.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package fetch_sequencer_pkg;

    localparam logic [1:0] CC_ALU = 2'b01;

    localparam logic [2:0] AM3_IZX = 3'b000;
    localparam logic [2:0] AM3_ZPG = 3'b001;
    localparam logic [2:0] AM3_IMM = 3'b010;
    localparam logic [2:0] AM3_ABS = 3'b011;
    localparam logic [2:0] AM3_IZY = 3'b100;
    localparam logic [2:0] AM3_ZPX = 3'b101;
    localparam logic [2:0] AM3_ABY = 3'b110;
    localparam logic [2:0] AM3_ABX = 3'b111;

    // Mode field meaning when the cc bits are not 01
    localparam logic [2:0] AM3_ALT_IMM = 3'b000;
    localparam logic [2:0] AM3_ALT_ZPG = 3'b001;
    localparam logic [2:0] AM3_ALT_ABS = 3'b011;
    localparam logic [2:0] AM3_ALT_ZPX = 3'b101;
    localparam logic [2:0] AM3_ALT_ABX = 3'b111;

    localparam logic [2:0] S_FETCH_OP  = 3'd0;
    localparam logic [2:0] S_FETCH_LO  = 3'd1;
    localparam logic [2:0] S_FETCH_HI  = 3'd2;
    localparam logic [2:0] S_PTR_LO    = 3'd3;
    localparam logic [2:0] S_PTR_HI    = 3'd4;
    localparam logic [2:0] S_FIXUP     = 3'd5;
    localparam logic [2:0] S_ISSUE     = 3'd6;
    localparam logic [2:0] S_WAIT_DONE = 3'd7;

    // Operand byte counts, 2 bits per mode, mode 7 in the top slot
    localparam logic [15:0] OPCNT_CC01  = {2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1};
    localparam logic [15:0] OPCNT_OTHER = {2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1};

    typedef enum logic [3:0] {
        AM_IMP, AM_IMM, AM_ZPG, AM_ZPX, AM_ABS, AM_ABX, AM_ABY, AM_IZX, AM_IZY
    } am_t;

    function automatic am_t decode_am(input logic [7:0] opcode);
        am_t am;
        am = AM_IMP;
        if (opcode[1:0] == CC_ALU) begin
            case (opcode[4:2])
                AM3_IZX: am = AM_IZX;
                AM3_ZPG: am = AM_ZPG;
                AM3_IMM: am = AM_IMM;
                AM3_ABS: am = AM_ABS;
                AM3_IZY: am = AM_IZY;
                AM3_ZPX: am = AM_ZPX;
                AM3_ABY: am = AM_ABY;
                AM3_ABX: am = AM_ABX;
            endcase
        end else begin
            case (opcode[4:2])
                AM3_ALT_IMM: am = AM_IMM;
                AM3_ALT_ZPG: am = AM_ZPG;
                AM3_ALT_ABS: am = AM_ABS;
                AM3_ALT_ZPX: am = AM_ZPX;
                AM3_ALT_ABX: am = AM_ABX;
                default:     am = AM_IMP;
            endcase
        end
        return am;
    endfunction

    function automatic logic [1:0] operand_count(input logic [7:0] opcode);
        logic [15:0] tbl;
        tbl = (opcode[1:0] == CC_ALU) ? OPCNT_CC01 : OPCNT_OTHER;
        return tbl[{opcode[4:2], 1'b0} +: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ea_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ea_adder                                                                 |
// | Base + zero-extended index adder; o_carry flags a low-byte carry-out.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ea_adder #(
    parameter int WIDTH     = 16,
    parameter int IDX_WIDTH = 8
) (
    input  logic [WIDTH-1:0]     i_base,
    input  logic [IDX_WIDTH-1:0] i_index,
    output logic [WIDTH-1:0]     o_sum,
    output logic                 o_carry
);
    logic [IDX_WIDTH:0] w_low;

    assign w_low   = {1'b0, i_base[IDX_WIDTH-1:0]} + {1'b0, i_index};
    assign o_carry = w_low[IDX_WIDTH];
    assign o_sum   = i_base + {{(WIDTH-IDX_WIDTH){1'b0}}, i_index};
endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_sequencer                                                          |
// | Opcode/operand fetch and effective-address sequencer with 2-clock reads. |
// | Option macro: PAGE_CROSS_PENALTY_EN (extra FIXUP clock on index carry).  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                    REG_WIDTH  = `REG_WIDTH,
    parameter int                    ADDR_WIDTH = `ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h8000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    input  logic [REG_WIDTH-1:0]  x_in,
    input  logic [REG_WIDTH-1:0]  y_in,
    input  logic                  instruction_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic [REG_WIDTH-1:0]  instruction,
    output logic [REG_WIDTH-1:0]  operand,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  instruction_ready,
    output logic [ADDR_WIDTH-1:0] pc
);
    // Absolute addresses are {hi,lo}, so ADDR_WIDTH is expected to be 2*REG_WIDTH
    localparam int C_ZP_PAD = ADDR_WIDTH - REG_WIDTH;

    logic [2:0]            r_state, w_state_nxt;
    logic                  r_phase, w_phase_nxt;
    logic [ADDR_WIDTH-1:0] r_pc, r_mem_addr, r_imm_addr, r_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr, w_ea, w_idx_sum, w_idx_base;
    logic [REG_WIDTH-1:0]  r_instruction, r_operand, r_lo, r_hi, r_plo, r_phi;
    logic [REG_WIDTH-1:0]  w_index, w_zpx, w_zp, w_zp_inc;
    logic                  r_mem_rd, r_ready;
    logic                  w_read_state, w_launch, w_capture;
    logic                  w_carry, w_fixup, w_indirect, w_indexed;
    logic [1:0]            w_opcnt, w_new_opcnt;
    am_t                   w_am;

    assign w_am        = decode_am(r_instruction);
    assign w_opcnt     = operand_count(r_instruction);
    assign w_new_opcnt = operand_count(mem_rdata);
    assign w_indirect  = (w_am == AM_IZX) || (w_am == AM_IZY);
    assign w_indexed   = (w_am == AM_ABX) || (w_am == AM_ABY) || (w_am == AM_IZY);
    assign w_index     = ((w_am == AM_ABY) || (w_am == AM_IZY)) ? y_in : x_in;
    assign w_idx_base  = (w_am == AM_IZY) ? {r_phi, r_plo} : {r_hi, r_lo};
    assign w_zpx       = r_lo + x_in;
    assign w_zp        = (w_am == AM_IZX) ? w_zpx : r_lo;
    assign w_zp_inc    = w_zp + 1'b1;

    ea_adder #(
        .WIDTH     (ADDR_WIDTH),
        .IDX_WIDTH (REG_WIDTH)
    ) u_ea_adder (
        .i_base  (w_idx_base),
        .i_index (w_index),
        .o_sum   (w_idx_sum),
        .o_carry (w_carry)
    );

    // The carry depends only on the low base byte, already held at the final capture
`ifdef PAGE_CROSS_PENALTY_EN
    assign w_fixup = w_carry & w_indexed;
`else
    logic w_unused_carry;
    assign w_unused_carry = w_carry & w_indexed;
    assign w_fixup        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH_OP;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = 1'b0;
        case (r_state)
            S_FETCH_OP:  if (!r_phase) w_phase_nxt = 1'b1;
                         else w_state_nxt = (w_new_opcnt == 2'd0) ? S_ISSUE : S_FETCH_LO;
            S_FETCH_LO:  if (!r_phase) w_phase_nxt = 1'b1;
                         else if (w_opcnt == 2'd2) w_state_nxt = S_FETCH_HI;
                         else if (w_indirect) w_state_nxt = S_PTR_LO;
                         else w_state_nxt = S_ISSUE;
            S_FETCH_HI:  if (!r_phase) w_phase_nxt = 1'b1;
                         else w_state_nxt = w_fixup ? S_FIXUP : S_ISSUE;
            S_PTR_LO:    if (!r_phase) w_phase_nxt = 1'b1;
                         else w_state_nxt = S_PTR_HI;
            S_PTR_HI:    if (!r_phase) w_phase_nxt = 1'b1;
                         else w_state_nxt = w_fixup ? S_FIXUP : S_ISSUE;
            S_FIXUP:     w_state_nxt = S_ISSUE;
            S_ISSUE:     w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (instruction_done) w_state_nxt = S_FETCH_OP;
            default:     w_state_nxt = S_FETCH_OP;
        endcase
    end

    always_comb begin
        w_read_state = 1'b0;
        w_rd_addr    = r_pc;
        case (r_state)
            S_FETCH_OP, S_FETCH_LO, S_FETCH_HI: w_read_state = 1'b1;
            S_PTR_LO: begin
                w_read_state = 1'b1;
                w_rd_addr    = {{C_ZP_PAD{1'b0}}, w_zp};
            end
            S_PTR_HI: begin
                w_read_state = 1'b1;
                w_rd_addr    = {{C_ZP_PAD{1'b0}}, w_zp_inc};
            end
            default: ;
        endcase
    end

    assign w_launch  = w_read_state & ~r_phase;
    assign w_capture = w_read_state & r_phase;

    always_comb begin
        w_ea = '0;
        case (w_am)
            AM_IMM:                 w_ea = r_imm_addr;
            AM_ZPG:                 w_ea = {{C_ZP_PAD{1'b0}}, r_lo};
            AM_ZPX:                 w_ea = {{C_ZP_PAD{1'b0}}, w_zpx};
            AM_ABS:                 w_ea = {r_hi, r_lo};
            AM_IZX:                 w_ea = {r_phi, r_plo};
            AM_ABX, AM_ABY, AM_IZY: w_ea = w_idx_sum;
            default:                w_ea = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_mem_addr    <= '0;
            r_mem_rd      <= 1'b0;
            r_instruction <= '0;
            r_operand     <= '0;
            r_addr        <= '0;
            r_ready       <= 1'b0;
            r_imm_addr    <= '0;
            r_lo          <= '0;
            r_hi          <= '0;
            r_plo         <= '0;
            r_phi         <= '0;
        end else begin
            r_mem_rd <= w_launch;
            if (w_launch)
                r_mem_addr <= w_rd_addr;
            if (w_capture) begin
                case (r_state)
                    S_FETCH_OP: begin
                        r_instruction <= mem_rdata;
                        r_operand     <= '0;
                    end
                    S_FETCH_LO: begin
                        r_lo       <= mem_rdata;
                        r_operand  <= mem_rdata;
                        r_imm_addr <= r_pc;
                    end
                    S_FETCH_HI: r_hi  <= mem_rdata;
                    S_PTR_LO:   r_plo <= mem_rdata;
                    S_PTR_HI:   r_phi <= mem_rdata;
                    default: ;
                endcase
                if ((r_state != S_PTR_LO) && (r_state != S_PTR_HI))
                    r_pc <= r_pc + 1'b1;
            end
            if (r_state == S_ISSUE) begin
                r_addr  <= w_ea;
                r_ready <= 1'b1;
            end else if ((r_state == S_WAIT_DONE) && instruction_done) begin
                r_ready <= 1'b0;
            end
        end
    end

    assign mem_addr          = r_mem_addr;
    assign mem_rd            = r_mem_rd;
    assign instruction       = r_instruction;
    assign operand           = r_operand;
    assign addr              = r_addr;
    assign instruction_ready = r_ready;
    assign pc                = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_sequencer                                                       |
// | Directed scenarios plus a scoreboarded back-to-back instruction stream.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fetch_sequencer;

`ifdef PAGE_CROSS_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, instruction_done;
    logic [7:0]  x_in, y_in, mem_rdata, instruction, operand;
    logic [15:0] mem_addr, addr, pc;
    logic        mem_rd, instruction_ready;

    logic        reset2_n, done2;
    logic [7:0]  mem_rdata2, instruction2, operand2;
    logic [15:0] mem_addr2, addr2, pc2;
    logic        mem_rd2, ready2;

    logic [7:0]  mem [0:65535];
    assign mem_rdata  = mem[mem_addr];
    assign mem_rdata2 = mem[mem_addr2];

    fetch_sequencer dut (
        .clk(clk), .reset_n(reset_n), .mem_rdata(mem_rdata), .x_in(x_in), .y_in(y_in),
        .instruction_done(instruction_done), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .instruction(instruction), .operand(operand), .addr(addr),
        .instruction_ready(instruction_ready), .pc(pc)
    );

    fetch_sequencer #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .reset_n(reset2_n), .mem_rdata(mem_rdata2), .x_in(x_in), .y_in(y_in),
        .instruction_done(done2), .mem_addr(mem_addr2), .mem_rd(mem_rd2),
        .instruction(instruction2), .operand(operand2), .addr(addr2),
        .instruction_ready(ready2), .pc(pc2)
    );

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  opnd;
        logic [15:0] addr;
        logic [15:0] pc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] rd_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always @(negedge clk) if (mem_rd === 1'b1) rd_log.push_back(mem_addr);

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        instruction_done = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        reset_n = 1'b1;
        rd_log.delete();
    endtask

    task automatic wait_ready(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (!ok && n < 40) begin
            tick();
            n++;
            if (instruction_ready === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        instruction_done = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (pc !== 16'h8000) begin n_fail++; $display("FAIL reset_pc: got %h want 8000", pc); end
        n_tests++;
        if ({mem_addr, mem_rd, instruction, operand, addr, instruction_ready} !== 50'd0) begin
            n_fail++;
            $display("FAIL reset_outs: mem_addr=%h rd=%b inst=%h opnd=%h addr=%h rdy=%b want all 0",
                     mem_addr, mem_rd, instruction, operand, addr, instruction_ready);
        end
    endtask

    task automatic test_imm();
        int n; bit ok;
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
        apply_reset();
        instruction_done = 1'b1;
        repeat (3) tick();
        instruction_done = 1'b0;
        wait_ready(n, ok);
        n_tests++;
        if (!ok || n + 3 != 5) begin n_fail++; $display("FAIL imm_latency: got %0d (ok=%0d) want 5", n + 3, ok); end
        n_tests++;
        if ({instruction, operand, addr, pc} !== {8'hA9, 8'h42, 16'h8001, 16'h8002}) begin
            n_fail++;
            $display("FAIL imm_fields: inst=%h opnd=%h addr=%h pc=%h want A9 42 8001 8002", instruction, operand, addr, pc);
        end
        n_tests++;
        if (rd_log.size() != 2 || rd_log[0] !== 16'h8000 || rd_log[1] !== 16'h8001) begin
            n_fail++; $display("FAIL imm_reads: got %0d reads first %h want 8000,8001", rd_log.size(), rd_log[0]);
        end
        instruction_done = 1'b1;
        tick();
        instruction_done = 1'b0;
        n_tests++;
        if (instruction_ready !== 1'b0) begin n_fail++; $display("FAIL imm_done_drop: got %b want 0", instruction_ready); end
    endtask

    task automatic test_abs_hold();
        int n; bit ok;
        mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
        apply_reset();
        wait_ready(n, ok);
        n_tests++;
        if (!ok || n != 7) begin n_fail++; $display("FAIL abs_latency: got %0d want 7", n); end
        n_tests++;
        if (addr !== 16'h1234) begin n_fail++; $display("FAIL abs_addr: got %h want 1234", addr); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if ({instruction_ready, instruction, addr} !== {1'b1, 8'hAD, 16'h1234}) begin
                n_fail++; $display("FAIL abs_hold: rdy=%b inst=%h addr=%h want 1 AD 1234", instruction_ready, instruction, addr);
            end
        end
        instruction_done = 1'b1;
        tick();
        instruction_done = 1'b0;
        n_tests++;
        if (instruction_ready !== 1'b0) begin n_fail++; $display("FAIL abs_done_drop: got %b want 0", instruction_ready); end
        tick();
        n_tests++;
        if ({mem_rd, mem_addr} !== {1'b1, 16'h8003}) begin
            n_fail++; $display("FAIL abs_next_read: rd=%b addr=%h want 1 8003", mem_rd, mem_addr);
        end
    endtask

    task automatic test_zpx_wrap();
        int n; bit ok;
        x_in = 8'h20;
        mem[16'h8000] = 8'hB5; mem[16'h8001] = 8'hF0;
        apply_reset();
        wait_ready(n, ok);
        n_tests++;
        if (!ok || n != 5 || addr !== 16'h0010) begin
            n_fail++; $display("FAIL zpx_wrap: lat=%0d addr=%h want 5 0010", n, addr);
        end
    endtask

    task automatic test_izy();
        int n; bit ok;
        logic [63:0] got;
        y_in = 8'h20;
        mem[16'h8000] = 8'hB1; mem[16'h8001] = 8'hFF;
        mem[16'h00FF] = 8'hF0; mem[16'h0000] = 8'h12;
        apply_reset();
        wait_ready(n, ok);
        n_tests++;
        if (!ok || n != 9 + PEN) begin n_fail++; $display("FAIL izy_latency: got %0d want %0d", n, 9 + PEN); end
        n_tests++;
        if (addr !== 16'h1310) begin n_fail++; $display("FAIL izy_addr: got %h want 1310", addr); end
        got = (rd_log.size() == 4) ? {rd_log[0], rd_log[1], rd_log[2], rd_log[3]} : 64'd0;
        n_tests++;
        if (got !== 64'h8000_8001_00FF_0000) begin
            n_fail++; $display("FAIL izy_reads: got %h want 8000800100ff0000", got);
        end
    endtask

    task automatic test_pc_wrap();
        int n; bit ok;
        mem[16'hFFFF] = 8'hEA;
        @(negedge clk);
        reset2_n = 1'b1;
        n = 0; ok = 1'b0;
        while (!ok && n < 40) begin
            tick();
            n++;
            if (ready2 === 1'b1) ok = 1'b1;
        end
        n_tests++;
        if (!ok || n != 3) begin n_fail++; $display("FAIL wrap_latency: got %0d want 3", n); end
        n_tests++;
        if ({pc2, instruction2, addr2, operand2} !== {16'h0000, 8'hEA, 16'h0000, 8'h00}) begin
            n_fail++; $display("FAIL wrap_fields: pc=%h inst=%h addr=%h opnd=%h want 0000 EA 0000 00", pc2, instruction2, addr2, operand2);
        end
        reset2_n = 1'b0;
    endtask

    task automatic test_reset_wait_done();
        int n; bit ok;
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
        apply_reset();
        wait_ready(n, ok);
        tick();
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({instruction_ready, mem_rd, pc, instruction, addr} !== {1'b0, 1'b0, 16'h8000, 8'h00, 16'h0000}) begin
            n_fail++; $display("FAIL rst_wait: rdy=%b rd=%b pc=%h inst=%h addr=%h want 0 0 8000 00 0000",
                               instruction_ready, mem_rd, pc, instruction, addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        n_tests++;
        if ({mem_rd, mem_addr} !== {1'b1, 16'h8000}) begin
            n_fail++; $display("FAIL rst_wait_restart: rd=%b addr=%h want 1 8000", mem_rd, mem_addr);
        end
    endtask

    task automatic put_instr(inout logic [15:0] lp, input logic [7:0] op, input logic [7:0] b1,
                             input logic [7:0] b2, input int nb, input logic [7:0] e_opnd,
                             input logic [15:0] e_addr, input int lat);
        exp_t e;
        mem[lp] = op;
        if (nb > 1) mem[lp + 16'd1] = b1;
        if (nb > 2) mem[lp + 16'd2] = b2;
        lp = lp + 16'(nb);
        e.op = op; e.opnd = e_opnd; e.addr = e_addr; e.pc = lp; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic test_back_to_back();
        int n; bit ok;
        logic [15:0] lp;
        exp_t e;
        x_in = 8'h05; y_in = 8'h20;
        mem[16'h0015] = 8'h34; mem[16'h0016] = 8'h56;
        lp = 16'h8000;
        put_instr(lp, 8'hA9, 8'h55, 8'h00, 2, 8'h55, 16'h8001, 5);
        put_instr(lp, 8'h65, 8'h80, 8'h00, 2, 8'h80, 16'h0080, 5);
        put_instr(lp, 8'h7D, 8'h00, 8'h12, 3, 8'h00, 16'h1205, 7);
        put_instr(lp, 8'hE8, 8'h00, 8'h00, 1, 8'h00, 16'h0000, 3);
        put_instr(lp, 8'hA1, 8'h10, 8'h00, 2, 8'h10, 16'h5634, 9);
        put_instr(lp, 8'hB9, 8'hFF, 8'h20, 3, 8'hFF, 16'h211F, 7 + PEN);
        put_instr(lp, 8'hB6, 8'hF8, 8'h00, 2, 8'hF8, 16'h00FD, 5);
        put_instr(lp, 8'hAE, 8'h00, 8'h30, 3, 8'h00, 16'h3000, 7);
        put_instr(lp, 8'hA2, 8'h7E, 8'h00, 2, 8'h7E, 16'h8013, 5);
        apply_reset();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_ready(n, ok);
            n_tests++;
            if (!ok || n != e.lat) begin
                n_fail++; $display("FAIL b2b_latency op %h: got %0d want %0d", e.op, n, e.lat);
            end
            n_tests++;
            if ({instruction, operand, addr, pc} !== {e.op, e.opnd, e.addr, e.pc}) begin
                n_fail++; $display("FAIL b2b_fields op %h: got %h %h %h %h want %h %h %h %h",
                                   e.op, instruction, operand, addr, pc, e.op, e.opnd, e.addr, e.pc);
            end
            instruction_done = 1'b1;
            tick();
            instruction_done = 1'b0;
            n_tests++;
            if (instruction_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done op %h: ready got %b want 0", e.op, instruction_ready); end
            if (!ok) sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        reset_n = 1'b0; reset2_n = 1'b0; done2 = 1'b0;
        instruction_done = 1'b0; x_in = 8'h00; y_in = 8'h00;
        test_reset();
        test_imm();
        test_abs_hold();
        test_zpx_wrap();
        test_izy();
        test_pc_wrap();
        test_reset_wait_done();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are named clk and reset_n.
REQ-002 Parameters SHALL be: REG_WIDTH, default `REG_WIDTH (8), data byte width; ADDR_WIDTH, default `ADDR_WIDTH (16), address width; RESET_PC, default 16'h8000, PC value after reset.
REQ-003 Ports, one per line:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- mem_rdata  in  8  read data, valid the clock after mem_rd
- x_in  in  8  X register value
- y_in  in  8  Y register value
- instruction_done  in  1  decoder completion strobe
- mem_addr  out  16  read address
- mem_rd  out  1  read request
- instruction  out  8  latched opcode
- operand  out  8  latched immediate byte
- addr  out  16  effective address
- instruction_ready  out  1  opcode/operand/addr valid
- pc  out  16  program counter

Function
REQ-004 Every memory read SHALL take 2 clocks: phase 0 drives mem_addr with mem_rd=1; phase 1 has mem_rd=0 and captures mem_rdata at the clock edge.
REQ-005 States SHALL be FETCH_OP, FETCH_LO, FETCH_HI, PTR_LO, PTR_HI, FIXUP, ISSUE and WAIT_DONE.
REQ-006 Each opcode or operand byte read SHALL use address pc, and pc SHALL increment by 1 at capture, wrapping 16'hFFFF->16'h0000.
REQ-007 Mode field is opcode[4:2]; for cc=opcode[1:0]=01, the operand counts and flows SHALL be:
- 000 (zp,X): 1 operand, then PTR_LO/PTR_HI
- 001 zpg: 1 operand
- 010 imm: 1 operand
- 011 abs: 2 operands
- 100 (zp),Y: 1 operand, then PTR_LO/PTR_HI
- 101 zpg,X: 1 operand
- 110 abs,Y: 2 operands
- 111 abs,X: 2 operands
REQ-008 For cc!=01, the mode mapping SHALL be 000 imm, 001 zpg, 011 abs, 101 zpg,X, 111 abs,X, and every other mode implied with 0 operands.
REQ-009 Effective address arithmetic SHALL be:
- zpg: {8'h00,lo}
- zpg,X: {8'h00,(lo+x_in) mod 256}
- abs: {hi,lo}
- abs,X / abs,Y: ({hi,lo}+index) mod 2^16
- (zp,X): pointer bytes read at {8'h00,(lo+x)} and {8'h00,(lo+x+1) mod 256}
- (zp),Y: pointer bytes read at {8'h00,lo} and {8'h00,(lo+1) mod 256}, then +y_in mod 2^16
REQ-010 For imm mode, operand SHALL hold the byte and addr SHALL hold the address it was fetched from; for implied mode, addr SHALL be 16'h0000.
REQ-011 After the final capture, the block SHALL enter ISSUE, assert instruction_ready in the next clock, and move to WAIT_DONE.
REQ-012 In WAIT_DONE, instruction_ready SHALL stay high, with instruction, operand and addr stable, until instruction_done is sampled high; ready SHALL then drop on that edge and the block SHALL enter FETCH_OP.
REQ-013 instruction_done sampled while instruction_ready=0 SHALL be ignored.
REQ-014 Opcode-to-ready latency SHALL be 3 clocks for implied, 5 for 1-operand, 7 for abs, and 9 for indirect modes.

Reset
REQ-015 Assertion of reset_n low SHALL asynchronously set:
- pc=RESET_PC
- state=FETCH_OP, phase 0
- mem_addr=0, mem_rd=0
- instruction=0, operand=0, addr=0
- instruction_ready=0
REQ-016 Reset mid-fetch or mid-WAIT_DONE SHALL abandon the instruction; the first read after release SHALL be at RESET_PC.

Configuration
REQ-017 With PAGE_CROSS_PENALTY_EN defined, abs,X / abs,Y / (zp),Y SHALL pass through FIXUP for one extra clock when the index add carries out of the low byte.
REQ-018 Without PAGE_CROSS_PENALTY_EN, FIXUP SHALL never be entered and latency SHALL be independent of the carry.

Structure
REQ-019 The addressing-mode codes (AM3_*), state encodings and operand-count table SHALL live in the shared defines header.
REQ-020 The 16-bit index adder with carry-out SHALL be a sub-module named ea_adder.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, mem[8000]=A9, mem[8001]=42 -> ready at clock 5; instruction=A9, operand=42, addr=8001, pc=8002.
- Opcode AD with bytes 34 12 -> addr=1234 at clock 7; ready held 3 clocks until done; next mem_addr=8003.
- Opcode B5 at zp F0 with x_in=20 -> addr=0010 (zero-page wrap).
- Opcode B1 with zp FF, mem[00FF]=F0, mem[0000]=12, y_in=20 -> pointer read at 00FF/0000; addr=1310; penalty build ready at clock 10, non-penalty at clock 9.
- pc=FFFF with opcode EA -> pc wraps to 0000, ready at clock 3.
- reset_n pulsed low during WAIT_DONE -> ready=0 immediately; next read at 8000.
